mem_store_checker: RTL and testbench

Synthesizable self-checking monitor for the processor's data-memory write port. It snoops `mem_write`/`data_addr`/`write_data` at the `top` boundary and compares each store against a programmable ordered list of expected (address, data) pairs. Stores to one configurable scratch address are tolerated. A run ends in registered pass/fail flags with a cause code and the offending store captured. It is the hardware successor to the single-store end-of-program check in the bench, so directed programs can check multi-store results on FPGA or in long regressions.

---
 rtl/mem_store_checker.sv | 136 +++++++++++++
 tb/tb_mem_store_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_checker.sv
// Data-memory store monitor: matches each snooped store against an ordered
// table of expected (address, data) pairs and ends in sticky pass/fail flags.
module mem_store_checker #(
  parameter int unsigned            WIDTH        = 32,
  parameter int unsigned            DEPTH        = 4,
  parameter logic [WIDTH-1:0]       SCRATCH_ADDR = WIDTH'(80),
  parameter int unsigned            TIMEOUT      = 1024,
  localparam int unsigned           NW           = $clog2(DEPTH + 1),
  localparam int unsigned           IW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NW-1:0]    n_expected,
  input  logic             exp_we,
  input  logic [IW-1:0]    exp_idx,
  input  logic [WIDTH-1:0] exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] data_addr,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [NW-1:0]    match_count,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           state, state_next;
  logic [NW-1:0]    n_lat, n_lat_next, n_sat, mc_next;
  logic [CW-1:0]    cyc, cyc_next;
  logic [1:0]       code_next;
  logic [WIDTH-1:0] fa_next, fd_next;
  logic             addr_hit, data_hit, timeout;

  logic [WIDTH-1:0] tab_addr [DEPTH];
  logic [WIDTH-1:0] tab_data [DEPTH];

  // Table has no reset so a run can be repeated after reset without reloading.
  always_ff @(posedge clk) begin
    if (exp_we && state != S_RUN && 32'(exp_idx) < DEPTH) begin
      tab_addr[exp_idx] <= exp_addr;
      tab_data[exp_idx] <= exp_data;
    end
  end

  assign addr_hit = (data_addr  == tab_addr[IW'(match_count)]);
  assign data_hit = (write_data == tab_data[IW'(match_count)]);
  assign timeout  = (cyc == CW'(TIMEOUT - 1));
  assign n_sat    = (n_expected > NW'(DEPTH)) ? NW'(DEPTH) : n_expected;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Store outcome is decided first; timeout only applies when the store
  // neither completed the run nor failed it.
  always_comb begin
    state_next = state;
    n_lat_next = n_lat;
    mc_next    = match_count;
    cyc_next   = cyc;
    code_next  = fail_code;
    fa_next    = fail_addr;
    fd_next    = fail_data;
    unique case (state)
      S_RUN: begin
        cyc_next = (cyc == '1) ? cyc : cyc + CW'(1);
        if (mem_write && addr_hit && data_hit) begin
          mc_next = match_count + NW'(1);
          if (mc_next == n_lat) begin
            state_next = S_PASS;
          end else if (timeout) begin
            state_next = S_FAIL;
            code_next  = 2'd3;
            fa_next    = '0;
            fd_next    = '0;
          end
        end else if (mem_write && (addr_hit || data_addr != SCRATCH_ADDR)) begin
          state_next = S_FAIL;
          code_next  = addr_hit ? 2'd1 : 2'd2;
          fa_next    = data_addr;
          fd_next    = write_data;
        end else if (timeout) begin
          state_next = S_FAIL;
          code_next  = 2'd3;
          fa_next    = '0;
          fd_next    = '0;
        end
      end
      default: begin
        if (start) begin
          n_lat_next = n_sat;
          mc_next    = '0;
          cyc_next   = '0;
          code_next  = 2'd0;
          fa_next    = '0;
          fd_next    = '0;
          state_next = (n_sat == '0) ? S_PASS : S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_lat       <= '0;
      cyc         <= '0;
      match_count <= '0;
      fail_code   <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      n_lat       <= n_lat_next;
      cyc         <= cyc_next;
      match_count <= mc_next;
      fail_code   <= code_next;
      fail_addr   <= fa_next;
      fail_data   <= fd_next;
      busy        <= (state_next == S_RUN);
      pass        <= (state_next == S_PASS);
      fail        <= (state_next == S_FAIL);
    end
  end

endmodule

// File: tb/tb_mem_store_checker.sv
// Directed bench for mem_store_checker with a short timeout so the timeout
// boundary is reachable in a few cycles.
module tb_mem_store_checker;

  logic        clk, reset, start, exp_we, mem_write;
  logic [2:0]  n_expected;
  logic [1:0]  exp_idx;
  logic [31:0] exp_addr, exp_data, data_addr, write_data;
  logic        busy, pass, fail;
  logic [1:0]  fail_code;
  logic [2:0]  match_count;
  logic [31:0] fail_addr, fail_data;

  int compared   = 0;
  int mismatched = 0;

  mem_store_checker #(
    .WIDTH(32),
    .DEPTH(4),
    .SCRATCH_ADDR(32'd80),
    .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .n_expected(n_expected),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .mem_write(mem_write), .data_addr(data_addr), .write_data(write_data),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
    .match_count(match_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = i; exp_addr = a; exp_data = d;
    step();
    exp_we = 1'b0;
  endtask

  task automatic go(input logic [2:0] n);
    n_expected = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; data_addr = a; write_data = d;
    step();
    mem_write = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_code"}, 32'(fail_code), 0);
    chk({tag, "_mc"},   32'(match_count), 0);
    chk({tag, "_faddr"}, fail_addr, 0);
    chk({tag, "_fdata"}, fail_data, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; exp_we = 1'b0; mem_write = 1'b0;
    n_expected = '0; exp_idx = '0; exp_addr = '0; exp_data = '0;
    data_addr = '0; write_data = '0;
    step(); step();
    chk_idle_zero("reset");
    reset = 1'b1;
    step();

    // Scratch stores are ignored, then the single entry matches.
    wr_entry(2'd0, 32'd84, 32'd7);
    go(3'd1);
    chk("t1_busy_rise", 32'(busy), 1);
    store(32'd80, 32'd5);
    store(32'd80, 32'd9);
    chk("t1_busy_scratch", 32'(busy), 1);
    chk("t1_mc_scratch", 32'(match_count), 0);
    store(32'd84, 32'd7);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_fail", 32'(fail), 0);
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_mc", 32'(match_count), 1);
    chk("t1_code", 32'(fail_code), 0);

    // Data mismatch, then stickiness against a later store.
    go(3'd1);
    chk("t2_mc_cleared", 32'(match_count), 0);
    chk("t2_pass_cleared", 32'(pass), 0);
    store(32'd84, 32'd6);
    chk("t2_fail", 32'(fail), 1);
    chk("t2_code", 32'(fail_code), 1);
    chk("t2_faddr", fail_addr, 84);
    chk("t2_fdata", fail_data, 6);
    store(32'd84, 32'd7);
    chk("t2_sticky_fail", 32'(fail), 1);
    chk("t2_sticky_code", 32'(fail_code), 1);

    // Unexpected address after one match.
    wr_entry(2'd1, 32'd88, 32'd3);
    go(3'd2);
    store(32'd84, 32'd7);
    chk("t3_mc1", 32'(match_count), 1);
    chk("t3_busy", 32'(busy), 1);
    store(32'd92, 32'd1);
    chk("t3_fail", 32'(fail), 1);
    chk("t3_code", 32'(fail_code), 2);
    chk("t3_faddr", fail_addr, 92);
    chk("t3_fdata", fail_data, 1);
    chk("t3_mc", 32'(match_count), 1);

    // Table write during RUN must be dropped.
    go(3'd2);
    wr_entry(2'd1, 32'd88, 32'd99);
    store(32'd84, 32'd7);
    store(32'd88, 32'd3);
    chk("t4_pass", 32'(pass), 1);
    chk("t4_mc", 32'(match_count), 2);

    // n_expected above DEPTH saturates; entry 2 lives at the scratch address.
    wr_entry(2'd2, 32'd80, 32'd11);
    wr_entry(2'd3, 32'd96, 32'd4);
    go(3'd7);
    store(32'd84, 32'd7);
    store(32'd88, 32'd3);
    store(32'd80, 32'd11);
    chk("t5_busy_before_last", 32'(busy), 1);
    store(32'd96, 32'd4);
    chk("t5_pass", 32'(pass), 1);
    chk("t5_mc", 32'(match_count), 4);

    // A scratch-address store that misses a scratch-address entry is a data mismatch.
    go(3'd3);
    store(32'd84, 32'd7);
    store(32'd88, 32'd3);
    store(32'd80, 32'd5);
    chk("t6_fail", 32'(fail), 1);
    chk("t6_code", 32'(fail_code), 1);
    chk("t6_faddr", fail_addr, 80);
    chk("t6_fdata", fail_data, 5);
    chk("t6_mc", 32'(match_count), 2);

    // Timeout: fail appears exactly 16 cycles after busy rises.
    go(3'd1);
    chk("t7_busy", 32'(busy), 1);
    repeat (15) step();
    chk("t7_no_fail_yet", 32'(fail), 0);
    chk("t7_busy_15", 32'(busy), 1);
    step();
    chk("t7_fail", 32'(fail), 1);
    chk("t7_code", 32'(fail_code), 3);
    chk("t7_faddr", fail_addr, 0);
    chk("t7_fdata", fail_data, 0);
    chk("t7_busy_fall", 32'(busy), 0);

    // Completing match on the timeout edge wins.
    go(3'd1);
    repeat (15) step();
    store(32'd84, 32'd7);
    chk("t8_pass", 32'(pass), 1);
    chk("t8_fail", 32'(fail), 0);
    chk("t8_code", 32'(fail_code), 0);

    // Non-final match on the timeout edge still times out.
    go(3'd2);
    repeat (15) step();
    store(32'd84, 32'd7);
    chk("t9_fail", 32'(fail), 1);
    chk("t9_code", 32'(fail_code), 3);
    chk("t9_mc", 32'(match_count), 1);
    chk("t9_faddr", fail_addr, 0);

    // Asynchronous reset mid-run, then n=0 and a fresh repeat with the kept table.
    go(3'd2);
    store(32'd84, 32'd7);
    chk("t10_mc1", 32'(match_count), 1);
    reset = 1'b0;
    #2;
    chk_idle_zero("t10_async");
    #10;
    reset = 1'b1;
    go(3'd0);
    chk("t10_n0_pass", 32'(pass), 1);
    chk("t10_n0_busy", 32'(busy), 0);
    go(3'd2);
    store(32'd84, 32'd7);
    store(32'd88, 32'd3);
    chk("t10_rerun_pass", 32'(pass), 1);
    chk("t10_rerun_mc", 32'(match_count), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
